// File: rtl/mem_check_pkg.sv
// Shared types and default constants for the store-stream checker and its store log.
package mem_check_pkg;

  typedef enum logic [2:0] {
    ST_RUN          = 3'd0,
    ST_PASS         = 3'd1,
    ST_FAIL_DATA    = 3'd2,
    ST_FAIL_ADDR    = 3'd3,
    ST_FAIL_TIMEOUT = 3'd4
  } chk_status_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_rec_t;

  localparam logic [31:0] DEF_PASS_ADDR  = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
  localparam logic [31:0] DEF_ALLOW_ADDR = 32'd80;

endpackage

// File: rtl/store_log_fifo.sv
// First-word fall-through FIFO of store records with a sticky drop flag.
module store_log_fifo
  import mem_check_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  store_rec_t push_data,
  input  logic       pop,
  output store_rec_t head,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  store_rec_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pop_ok, push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign overflow = ovf_q;
  // Head reads as zero when empty so the output is clean straight after reset.
  assign head     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push && !push_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_store_checker.sv
// Store-stream checker: sticky pass/fail verdict, run counters and optional store log.
// Define MEM_STORE_CHECKER_LOG_EN to build the store-log FIFO.
module mem_store_checker
  import mem_check_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
  parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR,
  parameter logic [31:0] TIMEOUT    = 32'd1000,
  parameter int          LOG_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic [2:0]  status,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count,
  input  logic        log_rd_en,
  output logic [63:0] log_rd_data,
  output logic        log_empty,
  output logic        log_overflow
);

  chk_status_t state_q, state_d;
  logic [15:0] store_cnt_q, store_cnt_d;
  logic [31:0] cycle_q, cycle_d;
  logic        done_q, done_d, pass_q, pass_d;
  logic        push;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    store_cnt_d = store_cnt_q;
    cycle_d     = cycle_q;
    push        = 1'b0;
    if (state_q == ST_RUN) begin
      cycle_d = cycle_q + 32'd1;
      if (memwrite) begin
        push        = !reset;
        store_cnt_d = sat_inc16(store_cnt_q);
        if (dataadr == PASS_ADDR && writedata == PASS_DATA) state_d = ST_PASS;
        else if (dataadr == PASS_ADDR)                      state_d = ST_FAIL_DATA;
        else if (dataadr != ALLOW_ADDR)                     state_d = ST_FAIL_ADDR;
      end
      // A terminal store on the timeout edge takes precedence.
      if (state_d == ST_RUN && cycle_q == TIMEOUT - 32'd1) state_d = ST_FAIL_TIMEOUT;
    end
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      store_cnt_q <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_cnt_q <= store_cnt_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign status      = state_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign store_count = store_cnt_q;
  assign cycle_count = cycle_q;

`ifdef MEM_STORE_CHECKER_LOG_EN
  store_rec_t push_rec, head_rec;
  logic       log_full_unused;

  assign push_rec = '{addr: dataadr, data: writedata};

  store_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .push_data(push_rec),
    .pop      (log_rd_en),
    .head     (head_rec),
    .empty    (log_empty),
    .full     (log_full_unused),
    .overflow (log_overflow)
  );

  assign log_rd_data = head_rec;
`else
  logic unused_log;

  assign unused_log   = log_rd_en ^ push;
  assign log_rd_data  = '0;
  assign log_empty    = 1'b1;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mem_store_checker.sv
// Directed bench for mem_store_checker (TIMEOUT=20, LOG_DEPTH=2): vector table plus timeout sequences.
module tb_mem_store_checker;
  logic        clk = 1'b0;
  logic        reset, memwrite, log_rd_en;
  logic [31:0] dataadr, writedata;
  logic        done, pass, log_empty, log_overflow;
  logic [2:0]  status;
  logic [15:0] store_count;
  logic [31:0] cycle_count;
  logic [63:0] log_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_store_checker #(.TIMEOUT(32'd20), .LOG_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .status(status),
    .store_count(store_count), .cycle_count(cycle_count), .log_rd_en(log_rd_en),
    .log_rd_data(log_rd_data), .log_empty(log_empty), .log_overflow(log_overflow)
  );

  typedef struct {
    logic        rst, we;
    logic [31:0] adr, dat;
    logic        rd;
    logic [2:0]  st;
    logic [15:0] sc;
    logic [31:0] cc;
    logic        emp;
    logic [63:0] rdd;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic we, int adr, int dat, logic rd,
                             int st, int sc, int cc, logic emp, int ra, int rdt, logic ovf);
    vec_t r;
    r.rst = rst; r.we = we; r.adr = adr; r.dat = dat; r.rd = rd;
    r.st = 3'(st); r.sc = 16'(sc); r.cc = cc; r.emp = emp;
    r.rdd = {32'(ra), 32'(rdt)}; r.ovf = ovf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [15:0] sc,
                           input logic [31:0] cc, input logic emp, input logic [63:0] rdd,
                           input logic ovf);
    chk({tag, ".status"}, 64'(status), 64'(st));
    chk({tag, ".done"}, 64'(done), 64'(st != 3'd0));
    chk({tag, ".pass"}, 64'(pass), 64'(st == 3'd1));
    chk({tag, ".store_count"}, 64'(store_count), 64'(sc));
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(cc));
`ifdef MEM_STORE_CHECKER_LOG_EN
    chk({tag, ".log_empty"}, 64'(log_empty), 64'(emp));
    chk({tag, ".log_rd_data"}, log_rd_data, rdd);
    chk({tag, ".log_overflow"}, 64'(log_overflow), 64'(ovf));
`else
    chk({tag, ".log_empty"}, 64'(log_empty), 64'd1);
    chk({tag, ".log_rd_data"}, log_rd_data, 64'd0);
    chk({tag, ".log_overflow"}, 64'(log_overflow), 64'd0);
`endif
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic rd);
    reset = rst; memwrite = we; dataadr = adr; writedata = dat; log_rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; log_rd_en = 1'b0;

    //            rst we adr dat  rd  st sc cc emp  head       ovf
    // PASS run; third push happens on a full log together with a pop
    tbl.push_back(v(1, 0,  0, 0,    0, 0, 0, 0, 1,  0, 0,    0));
    tbl.push_back(v(0, 1, 80, 'h11, 0, 0, 1, 1, 0, 80, 'h11, 0));
    tbl.push_back(v(0, 1, 80, 'h22, 0, 0, 2, 2, 0, 80, 'h11, 0));
    tbl.push_back(v(0, 1, 84, 7,    1, 1, 3, 3, 0, 80, 'h22, 0));
    tbl.push_back(v(0, 0,  0, 0,    1, 1, 3, 3, 0, 84, 7,    0));
    tbl.push_back(v(0, 0,  0, 0,    1, 1, 3, 3, 1,  0, 0,    0));
    tbl.push_back(v(0, 1, 80, 1,    0, 1, 3, 3, 1,  0, 0,    0));
    // reset in PASS with a simultaneous store
    tbl.push_back(v(1, 1, 84, 7,    0, 0, 0, 0, 1,  0, 0,    0));
    // FAIL_DATA, later good store ignored
    tbl.push_back(v(0, 1, 84, 5,    0, 2, 1, 1, 0, 84, 5,    0));
    tbl.push_back(v(0, 1, 84, 7,    0, 2, 1, 1, 0, 84, 5,    0));
    tbl.push_back(v(1, 0,  0, 0,    0, 0, 0, 0, 1,  0, 0,    0));
    // FAIL_ADDR, cycle_count frozen
    tbl.push_back(v(0, 0,  0, 0,    0, 0, 0, 1, 1,  0, 0,    0));
    tbl.push_back(v(0, 1, 88, 7,    0, 3, 1, 2, 0, 88, 7,    0));
    tbl.push_back(v(0, 0,  0, 0,    0, 3, 1, 2, 0, 88, 7,    0));
    tbl.push_back(v(0, 1, 80, 9,    0, 3, 1, 2, 0, 88, 7,    0));
    tbl.push_back(v(1, 0,  0, 0,    0, 0, 0, 0, 1,  0, 0,    0));
    // overflow with depth 2, then drain and pop-when-empty
    tbl.push_back(v(0, 1, 80, 1,    0, 0, 1, 1, 0, 80, 1,    0));
    tbl.push_back(v(0, 1, 80, 2,    0, 0, 2, 2, 0, 80, 1,    0));
    tbl.push_back(v(0, 1, 80, 3,    0, 0, 3, 3, 0, 80, 1,    1));
    tbl.push_back(v(0, 0,  0, 0,    1, 0, 3, 4, 0, 80, 2,    1));
    tbl.push_back(v(0, 0,  0, 0,    1, 0, 3, 5, 1,  0, 0,    1));
    tbl.push_back(v(0, 0,  0, 0,    1, 0, 3, 6, 1,  0, 0,    1));
    tbl.push_back(v(1, 0,  0, 0,    0, 0, 0, 0, 1,  0, 0,    0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].rd);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].sc, tbl[i].cc,
                tbl[i].emp, tbl[i].rdd, tbl[i].ovf);
    end

    // Timeout with no stores: RUN through edge 19, FAIL_TIMEOUT after edge 20
    for (int e = 1; e <= 19; e++) drive(0, 0, 0, 0, 0);
    check_all("to_edge19", 3'd0, 16'd0, 32'd19, 1'b1, 64'd0, 1'b0);
    drive(0, 0, 0, 0, 0);
    check_all("to_edge20", 3'd4, 16'd0, 32'd20, 1'b1, 64'd0, 1'b0);
    drive(0, 1, 84, 7, 0);
    check_all("to_after", 3'd4, 16'd0, 32'd20, 1'b1, 64'd0, 1'b0);

    // Terminal store on the 20th edge beats the timeout
    drive(1, 0, 0, 0, 0);
    check_all("race_rst", 3'd0, 16'd0, 32'd0, 1'b1, 64'd0, 1'b0);
    for (int e = 1; e <= 19; e++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 84, 7, 0);
    check_all("race_edge20", 3'd1, 16'd1, 32'd20, 1'b0, {32'd84, 32'd7}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
